// File: rtl/servo_pulse_meter.sv
// -----------------------------------------------------------------------------
// servo_pulse_meter
//   Measures the high time of an RC servo PWM input in whole microseconds.
//   Accepted widths (MIN_US..MAX_US) are published on pulse_len with a
//   one-cycle valid strobe. Out-of-range pulses give a one-cycle error strobe.
//   signal_lost is set once TIMEOUT_US elapses without an accepted pulse.
//
// Ports
//   CLK          in   system clock (CLK_F cycles per microsecond)
//   RST          in   asynchronous, active-high reset
//   CONTROL_PIN  in   servo PWM input, asynchronous to CLK
//   pulse_len    out  [15:0] last accepted pulse width in microseconds
//   valid        out  one-cycle strobe when pulse_len updates
//   error        out  one-cycle strobe on a rejected pulse
//   signal_lost  out  high while no accepted pulse has arrived for TIMEOUT_US
// -----------------------------------------------------------------------------
module servo_pulse_meter #(
  parameter int unsigned CLK_F      = 100,
  parameter int unsigned MIN_US     = 500,
  parameter int unsigned MAX_US     = 2500,
  parameter int unsigned TIMEOUT_US = 25000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CONTROL_PIN,
  output logic [15:0] pulse_len,
  output logic        valid,
  output logic        error,
  output logic        signal_lost
);

  localparam int unsigned     PRE_W    = $clog2(CLK_F);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_F - 1);
  localparam logic [15:0]     W_MIN    = 16'(MIN_US);
  localparam logic [15:0]     W_MAX    = 16'(MAX_US);
  localparam logic [15:0]     W_SAT    = 16'(MAX_US + 1);
  localparam logic [15:0]     TO_MAX   = 16'(TIMEOUT_US);

  typedef enum logic [1:0] {
    WAIT_LOW = 2'd0,
    ARMED    = 2'd1,
    HIGH     = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_s1, r_s2, r_s2_d;
  logic             r_primed;
  logic [PRE_W-1:0] r_pre;
  logic [15:0]      r_width;
  logic [15:0]      r_to;
  logic [15:0]      r_len;
  logic             r_valid, r_error, r_lost;

  logic             w_rise, w_fall, w_tick;
  logic             w_width_inc;
  logic [15:0]      w_width_nxt;
  logic             w_accept, w_reject;

  assign w_rise = r_s2 & ~r_s2_d;
  assign w_fall = ~r_s2 & r_s2_d;
  assign w_tick = (r_pre == PRE_LAST);

  // The width is judged on the value it takes at this edge, so a tick in the
  // fall-detect cycle still counts; this makes width = floor(N / CLK_F).
  assign w_width_inc = (r_state == HIGH) && w_tick && (r_width != W_SAT);
  assign w_width_nxt = r_width + {15'd0, w_width_inc};

  // Input conditioning and the one-cycle-after-reset qualifier.
  // NOTE: every register here holds state across cycles, so all use
  // non-blocking assignments and all get an explicit reset value.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_s2_d   <= 1'b0;
      r_primed <= 1'b0;
    end else begin
      r_s1     <= CONTROL_PIN;
      r_s2     <= r_s1;
      r_s2_d   <= r_s2;
      r_primed <= 1'b1;
    end
  end

  // Microsecond prescaler, re-phased to each rising edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)            r_pre <= '0;
    else if (w_rise)    r_pre <= '0;
    else if (w_tick)    r_pre <= '0;
    else                r_pre <= r_pre + 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)         r_width <= '0;
    else if (w_rise) r_width <= '0;
    else             r_width <= w_width_nxt;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= WAIT_LOW;
    else     r_state <= w_state_nxt;
  end

  // WAIT_LOW leaves only once the synchronizer holds real pin samples
  // (r_primed) and both stages read low. The zeros left in s1/s2 by reset
  // therefore cannot arm the meter under a pulse already in progress.
  // NOTE: defaults first so no path through the case leaves a signal
  // unassigned and infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    case (r_state)
      WAIT_LOW: if (r_primed && !r_s1 && !r_s2) w_state_nxt = ARMED;
      ARMED:    if (w_rise) w_state_nxt = HIGH;
      HIGH: begin
        if (w_fall) begin
          w_state_nxt = ARMED;
          if (w_width_nxt >= W_MIN && w_width_nxt <= W_MAX) w_accept = 1'b1;
          else                                              w_reject = 1'b1;
        end else if (w_width_nxt == W_SAT) begin
          // Over-length: reject now and ignore the eventual fall.
          w_reject    = 1'b1;
          w_state_nxt = WAIT_LOW;
        end
      end
      default: w_state_nxt = WAIT_LOW;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_len   <= '0;
      r_valid <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_valid <= w_accept;
      r_error <= w_reject;
      if (w_accept) r_len <= w_width_nxt;
    end
  end

  // Timeout counter restarts with each accepted pulse. signal_lost is
  // sticky from reset: it only drops after a valid strobe.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                         r_to <= '0;
    else if (w_accept)               r_to <= '0;
    else if (w_tick && r_to != TO_MAX) r_to <= r_to + 16'd1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                 r_lost <= 1'b1;
    else if (r_valid)        r_lost <= 1'b0;
    else if (r_to == TO_MAX) r_lost <= 1'b1;
  end

  assign pulse_len   = r_len;
  assign valid       = r_valid;
  assign error       = r_error;
  assign signal_lost = r_lost;

endmodule

// File: tb/tb_servo_pulse_meter.sv
// -----------------------------------------------------------------------------
// tb_servo_pulse_meter
//   Self-checking bench for servo_pulse_meter with time-scaled parameters.
//   Expected results come from the pulse-level rule: width = floor(N/CLK_F),
//   accepted when MIN_US <= width <= MAX_US, otherwise one error strobe.
// -----------------------------------------------------------------------------
module tb_servo_pulse_meter;

  localparam int CLK_F      = 4;
  localparam int MIN_US     = 20;
  localparam int MAX_US     = 100;
  localparam int TIMEOUT_US = 600;

  logic        CLK;
  logic        RST;
  logic        CONTROL_PIN;
  logic [15:0] pulse_len;
  logic        valid;
  logic        error;
  logic        signal_lost;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int exp_nvalid = 0;
  int exp_nerr   = 0;
  int exp_len    = 0;

  // Strobe monitor
  int mon_nvalid = 0;
  int mon_nerr   = 0;
  bit mon_bad    = 0;
  bit prev_strobe = 0;

  servo_pulse_meter #(
    .CLK_F(CLK_F), .MIN_US(MIN_US), .MAX_US(MAX_US), .TIMEOUT_US(TIMEOUT_US)
  ) dut (
    .CLK(CLK), .RST(RST), .CONTROL_PIN(CONTROL_PIN),
    .pulse_len(pulse_len), .valid(valid), .error(error),
    .signal_lost(signal_lost)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (RST) begin
      prev_strobe = 0;
    end else begin
      if (valid) mon_nvalid++;
      if (error) mon_nerr++;
      if ((valid && error) || ((valid || error) && prev_strobe)) mon_bad = 1;
      prev_strobe = valid || error;
    end
  end

  // Drive one pulse of n_high sampled-high cycles, then n_low low cycles,
  // and update the model assuming the meter is armed.
  task automatic send_pulse(input int n_high, input int n_low);
    int w;
    @(negedge CLK);
    CONTROL_PIN = 1'b1;
    repeat (n_high) @(negedge CLK);
    CONTROL_PIN = 1'b0;
    repeat (n_low) @(negedge CLK);
    w = n_high / CLK_F;
    if (w >= MIN_US && w <= MAX_US) begin
      exp_nvalid++;
      exp_len = w;
    end else begin
      exp_nerr++;
    end
  endtask

  task automatic compare_counts(input string name);
    checks++;
    if (mon_nvalid !== exp_nvalid) begin
      errors++;
      $display("FAIL %s valid_count got %0d exp %0d", name, mon_nvalid, exp_nvalid);
    end
    checks++;
    if (mon_nerr !== exp_nerr) begin
      errors++;
      $display("FAIL %s error_count got %0d exp %0d", name, mon_nerr, exp_nerr);
    end
    checks++;
    if (pulse_len !== 16'(exp_len)) begin
      errors++;
      $display("FAIL %s pulse_len got %0d exp %0d", name, pulse_len, exp_len);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (pulse_len !== 16'd0 || valid !== 1'b0 || error !== 1'b0 || signal_lost !== 1'b1) begin
      errors++;
      $display("FAIL %s outputs got len=%0d v=%b e=%b lost=%b exp 0/0/0/1",
               name, pulse_len, valid, error, signal_lost);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    CONTROL_PIN = 1'b0;
    repeat (3) @(negedge CLK);
    check_reset_outputs("reset_hold");
    RST = 1'b0;
    repeat (20) @(negedge CLK);
    checks++;
    if (signal_lost !== 1'b1 || valid !== 1'b0 || error !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle got v=%b e=%b lost=%b exp 0/0/1", valid, error, signal_lost);
    end
  endtask

  task automatic test_nominal();
    for (int i = 0; i < 3; i++) begin
      send_pulse(60 * CLK_F, 100);
      compare_counts("nominal");
      checks++;
      if (signal_lost !== 1'b0) begin
        errors++;
        $display("FAIL nominal_lost got %b exp 0", signal_lost);
      end
    end
  endtask

  task automatic test_bounds();
    int base_err;
    int base_val;
    send_pulse((MIN_US - 1) * CLK_F + CLK_F - 1, 10);   // floor = MIN-1
    compare_counts("bound_below_min");
    send_pulse(MIN_US * CLK_F, 10);
    compare_counts("bound_min");
    send_pulse(MAX_US * CLK_F + CLK_F - 1, 10);          // floor = MAX
    compare_counts("bound_max");
    send_pulse((MAX_US + 1) * CLK_F, 10);                // floor = MAX+1
    compare_counts("bound_above_max");
    // Long pulse: error must arrive while the pin is still high.
    base_err = mon_nerr;
    base_val = mon_nvalid;
    @(negedge CLK);
    CONTROL_PIN = 1'b1;
    repeat ((MAX_US + 1) * CLK_F + 40) @(negedge CLK);
    checks++;
    if (mon_nerr - base_err !== 1) begin
      errors++;
      $display("FAIL overlen_while_high errors got %0d exp 1", mon_nerr - base_err);
    end
    CONTROL_PIN = 1'b0;
    repeat (10) @(negedge CLK);
    exp_nerr++;
    checks++;
    if (mon_nerr - base_err !== 1 || mon_nvalid - base_val !== 0) begin
      errors++;
      $display("FAIL overlen_fall got err=%0d val=%0d exp 1/0",
               mon_nerr - base_err, mon_nvalid - base_val);
    end
    compare_counts("overlen_hold");
  endtask

  task automatic test_latency();
    int edges_seen;
    @(negedge CLK);
    CONTROL_PIN = 1'b1;
    repeat (40 * CLK_F) @(negedge CLK);
    CONTROL_PIN = 1'b0;                 // next posedge is edge k
    edges_seen = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge CLK);
      if (valid && edges_seen == 0) edges_seen = i;
    end
    exp_nvalid++;
    exp_len = 40;
    checks++;
    if (edges_seen !== 3) begin
      errors++;
      $display("FAIL latency edges got %0d exp 3", edges_seen);
    end
    compare_counts("latency");
  endtask

  task automatic test_random();
    int n_high;
    int n_low;
    for (int i = 0; i < 25; i++) begin
      n_high = $urandom_range((MAX_US + 2) * CLK_F, (MIN_US - 2) * CLK_F);
      n_low  = $urandom_range(60, 6);
      send_pulse(n_high, n_low);
      compare_counts("random");
    end
  endtask

  task automatic test_back_to_back();
    send_pulse(30 * CLK_F + 1, 2);
    send_pulse(45 * CLK_F + 2, 10);
    compare_counts("back_to_back");
  endtask

  task automatic test_high_at_reset();
    @(negedge CLK);
    CONTROL_PIN = 1'b1;
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    exp_len = 0;
    repeat (40 * CLK_F) @(negedge CLK);
    CONTROL_PIN = 1'b0;
    repeat (20) @(negedge CLK);
    compare_counts("high_at_reset_first");
    send_pulse(48 * CLK_F, 10);
    compare_counts("high_at_reset_next");
  endtask

  task automatic test_timeout();
    int d;
    bit got;
    send_pulse(40 * CLK_F, 0);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge CLK);
      if (valid) got = 1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL timeout_first_valid got none exp strobe");
    end
    d = 0;
    got = 0;
    while (!got && d < (TIMEOUT_US + 2) * CLK_F) begin
      @(negedge CLK);
      d++;
      if (signal_lost) got = 1;
    end
    checks++;
    if (!got || d < (TIMEOUT_US - 1) * CLK_F || d > (TIMEOUT_US + 1) * CLK_F) begin
      errors++;
      $display("FAIL timeout_rise got %0d cycles exp %0d..%0d", d,
               (TIMEOUT_US - 1) * CLK_F, (TIMEOUT_US + 1) * CLK_F);
    end
    compare_counts("timeout_wait");
    // Recovery pulse: lost stays high in the valid cycle, clears the next.
    @(negedge CLK);
    CONTROL_PIN = 1'b1;
    repeat (40 * CLK_F) @(negedge CLK);
    CONTROL_PIN = 1'b0;
    exp_nvalid++;
    exp_len = 40;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge CLK);
      if (valid) got = 1;
    end
    checks++;
    if (!got || signal_lost !== 1'b1) begin
      errors++;
      $display("FAIL timeout_recover_strobe got valid=%b lost=%b exp 1/1", got, signal_lost);
    end
    @(negedge CLK);
    checks++;
    if (signal_lost !== 1'b0) begin
      errors++;
      $display("FAIL timeout_recover_lost got %b exp 0", signal_lost);
    end
    repeat (5) @(negedge CLK);
    compare_counts("timeout_recover");
  endtask

  task automatic test_reset_mid_pulse();
    @(negedge CLK);
    CONTROL_PIN = 1'b1;
    repeat (32 * CLK_F) @(negedge CLK);
    #2;
    RST = 1'b1;
    #1;
    check_reset_outputs("reset_async");
    repeat (8 * CLK_F) @(negedge CLK);
    check_reset_outputs("reset_mid_hold");
    RST = 1'b0;
    exp_len = 0;
    repeat (20 * CLK_F) @(negedge CLK);
    CONTROL_PIN = 1'b0;
    repeat (20) @(negedge CLK);
    compare_counts("reset_mid_fall");
    send_pulse(60 * CLK_F, 10);
    compare_counts("reset_mid_next");
  endtask

  task automatic test_strobe_rules();
    checks++;
    if (mon_bad !== 1'b0) begin
      errors++;
      $display("FAIL strobe_rules got overlap=%b exp 0", mon_bad);
    end
  endtask

  initial begin
    RST = 1'b1;
    CONTROL_PIN = 1'b0;
    test_reset();
    test_nominal();
    test_bounds();
    test_latency();
    test_random();
    test_back_to_back();
    test_high_at_reset();
    test_timeout();
    test_reset_mid_pulse();
    test_strobe_rules();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/servo_pulse_meter.md
# servo_pulse_meter

Measures the high time of an incoming RC servo PWM signal, such as an RC receiver channel or a `servo` output looped back. It reports the width in whole microseconds, with a one-cycle valid strobe and error and signal-lost flags. This is the receive side of the servo pulse interface. It sits beside `servo`/`servo_tester`, and its `pulse_len` output feeds the same 16-bit microsecond format that `servo` consumes.

## Interface
Parameters:
- `CLK_F`, 100, clock frequency in MHz, i.e. CLK cycles per microsecond (≥2).
- `MIN_US`, 500, shortest accepted pulse in µs.
- `MAX_US`, 2500, longest accepted pulse in µs.
- `TIMEOUT_US`, 25000, µs without a valid pulse before `signal_lost` sets (< 65535).

Ports:
- `CLK`  in  1  system clock. One clock; reset is asynchronous and active-high.
- `RST`  in  1  asynchronous, active-high reset.
- `CONTROL_PIN`  in  1  servo PWM input, asynchronous to CLK.
- `pulse_len`  out  16  last accepted pulse width in µs.
- `valid`  out  1  one-cycle strobe when `pulse_len` updates.
- `error`  out  1  one-cycle strobe on a rejected pulse.
- `signal_lost`  out  1  level; high while no valid pulse has arrived for ≥ `TIMEOUT_US`.

## Operation
Input conditioning:
- `CONTROL_PIN` passes through a 2-FF synchronizer (`s1`, `s2`) and a registered copy `s2_d`.
- Rise = `s2 & ~s2_d`. Fall = `~s2 & s2_d`.

µs prescaler:
- Counter `pre` runs 0..CLK_F-1 and wraps; `tick` = (`pre` == CLK_F-1).
- `pre` is forced to 0 on a rise.

Width counter:
- 16 bits, cleared on a rise.
- Increments on `tick` while in state HIGH.
- Saturates at MAX_US+1.

State machine:
- WAIT_LOW (reset state):
  - `s2`=0 → ARMED.
  - A pulse already in progress at reset or after an error is never measured.
- ARMED:
  - Rise → HIGH (width=0, pre=0).
- HIGH, on fall:
  - If MIN_US ≤ width ≤ MAX_US: `pulse_len`←width, `valid`=1 for one cycle.
  - Else `error`=1 for one cycle; `pulse_len` holds.
  - Next state is ARMED in both cases.
- HIGH, width reaching MAX_US+1 while still high:
  - `error`=1 for one cycle, then WAIT_LOW.
  - The later fall produces no strobe.

Timeout:
- Separate 16-bit counter incremented on every `tick`, saturating at TIMEOUT_US.
- Cleared when `valid` fires.
- `signal_lost` = (count == TIMEOUT_US), registered.

Reset values:
- `pulse_len`=0, `valid`=0, `error`=0, `signal_lost`=1.
- state=WAIT_LOW; all counters, synchronizer and `s2_d` = 0.

## Timing
- Width equals floor(N / CLK_F), where N is the number of CLK edges at which `s1` sampled high.
  - Example: 150000 high cycles at CLK_F=100 gives 1500.
- Latency:
  - Let k be the first CLK edge at which `CONTROL_PIN` is sampled low after a pulse.
  - Fall is detected in the cycle after edge k+1.
  - `valid`/`error` and the new `pulse_len` are visible in the cycle after edge k+2.
- Over-length error fires in the cycle after the `tick` that makes width = MAX_US+1.
- `valid` and `error` are mutually exclusive and never high on consecutive cycles for the same pulse.
- A rise detected in the same cycle as a pending strobe starts a new measurement normally.
  - Minimum low time between pulses: 2 CLK cycles.
- Glitches shorter than 1 CLK may be missed.
  - A captured glitch measures width 0 and produces `error` (if MIN_US>0).
- `signal_lost`:
  - Falls in the cycle after `valid`.
  - Rises TIMEOUT_US µs (±1 µs) after the last `valid`, or after reset release.
- Asynchronous `RST` mid-pulse: all outputs go immediately to their reset values. The interrupted pulse is discarded via WAIT_LOW.

## Test plan
Run with CLK_F=10, MIN_US=500, MAX_US=2500, TIMEOUT_US=25000 unless noted.
- **Nominal pulse:** 15000-cycle high pulse every 20 ms → `valid` one cycle, `pulse_len`=1500, `error`=0; `signal_lost` clears after the first pulse.
- **Bounds:** pulses of 499, 500, 2500 and 2501 µs → 499 gives `error` with `pulse_len` held; 500 and 2500 give `valid`; 2501 gives `error` while still high, with no strobe at its fall.
- **High at reset:** pin high at reset release, falls after 1000 µs, then a 1200 µs pulse → no strobe for the first fall; `valid` with `pulse_len`=1200.
- **Timeout:** a valid pulse, then pin held low for 30 ms → `signal_lost`=1 about 25000 µs after the strobe; the next 1000 µs pulse gives `valid`, then `signal_lost`=0.
- **Reset mid-pulse:** assert `RST` 800 µs into a 1500 µs pulse and release at 1000 µs → outputs are 0/0/0/1 during reset; no strobe at the fall; the next 1500 µs pulse is measured as 1500.
- **Latency check:** count cycles from the first low sample to `valid` → exactly 3 edges, matching the Timing section.
